// File: rtl/fp16_cvt_pkg.sv
// Shared defaults and the requester-ID type for the FP16->INT8 converter arbiter.
package fp16_cvt_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int CVT_LAT_DEF   = 4;
    localparam int TAG_DEPTH_DEF = 8;

    typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/cvt_tag_fifo.sv
// Tag FIFO holding the owner ID of every conversion in flight; first-word fall-through.
module cvt_tag_fifo
    import fp16_cvt_pkg::*;
#(
    parameter int WIDTH = $bits(req_id_t),
    parameter int DEPTH = TAG_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp16_cvt_arbiter.sv
// Round-robin sharing of one FP16->INT8 converter among N_REQ requesters,
// with in-order return of each result to its owner via a tag FIFO.
module fp16_cvt_arbiter
    import fp16_cvt_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int CVT_LAT   = CVT_LAT_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*16-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     cvt_valid_o,
    output logic [15:0]              cvt_data_o,
    input  logic [7:0]               cvt_data_i,
    input  logic                     cvt_update_i,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [7:0]               rsp_data,
    output logic                     busy,
    output logic                     err
);

    localparam int ID_W = $clog2(N_REQ);
    // Never size below the converter's round trip, or throughput collapses.
    localparam int FIFO_DEPTH = (TAG_DEPTH < CVT_LAT + 2) ? CVT_LAT + 2 : TAG_DEPTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [N_REQ-1:0][15:0] lane_data;
    logic [ID_W-1:0]        last, cand, grant_id, tag_head;
    logic                   found, can_grant, push, pop;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    assign lane_data = req_data;
    assign pop       = cvt_update_i && !fifo_empty;
    assign can_grant = en && !rst && (!fifo_full || pop);
    assign push      = found && can_grant;
    assign busy      = (fifo_count != '0) || cvt_valid_o;

    // Search starts just after the last winner and wraps modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        grant_id = last;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (push)
            req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= ID_W'(N_REQ - 1);
            cvt_valid_o <= 1'b0;
            cvt_data_o  <= '0;
        end else begin
            cvt_valid_o <= push;
            if (push) begin
                cvt_data_o <= lane_data[grant_id];
                last       <= grant_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                rsp_id   <= tag_head;
                rsp_data <= cvt_data_i;
            end
            // A result with no owner is a converter protocol violation; sticky until reset.
            if (cvt_update_i && fifo_empty)
                err <= 1'b1;
        end
    end

    cvt_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (grant_id),
        .dout  (tag_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fp16_cvt_arbiter.sv
// Bench for fp16_cvt_arbiter with a behavioural fixed-latency FP16->INT8 converter attached.
module tb_fp16_cvt_arbiter;

    localparam int NR    = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = LAT + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en;
    logic [NR-1:0]      req_valid;
    logic [NR*16-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               cvt_valid_o;
    logic [15:0]        cvt_data_o;
    logic [7:0]         cvt_data_i;
    logic               cvt_update_i;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [7:0]         rsp_data;
    logic               busy;
    logic               err;

    // manual mode lets the bench stall the converter or inject spurious results
    logic               man, man_upd;
    logic [7:0]         man_data;
    logic [LAT-1:0]     cv_pipe;
    logic [LAT-1:0][7:0] cd_pipe;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp16_cvt_arbiter #(.N_REQ(NR), .CVT_LAT(LAT), .TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cvt_valid_o(cvt_valid_o), .cvt_data_o(cvt_data_o),
        .cvt_data_i(cvt_data_i), .cvt_update_i(cvt_update_i), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .err(err)
    );

    // truncating FP16 -> sign-magnitude INT8, 0xFF on overflow/Inf/NaN
    function automatic logic [7:0] f2i(input logic [15:0] h);
        int e;
        int mag;
        e = int'(h[14:10]);
        if (e >= 22) return 8'hFF;
        if (e < 15) mag = 0;
        else mag = (1024 + int'(h[9:0])) >> (25 - e);
        return {h[15], 7'(mag)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_pipe <= '0;
            cd_pipe <= '0;
        end else begin
            cv_pipe <= {cv_pipe[LAT-2:0], cvt_valid_o};
            cd_pipe <= {cd_pipe[LAT-2:0], f2i(cvt_data_o)};
        end
    end

    assign cvt_update_i = man ? man_upd  : cv_pipe[LAT-1];
    assign cvt_data_i   = man ? man_data : cd_pipe[LAT-1];

    // reference model state
    int          m_last;
    int          q_id[$];
    logic [15:0] q_op[$];
    logic        e_cvt_valid, e_rsp_valid, e_err;
    logic [15:0] e_cvt_data;
    logic [1:0]  e_rsp_id;
    logic [7:0]  e_rsp_data;
    int          grant_log[$];
    int          rsp_log_id[$];
    logic [7:0]  rsp_log_d[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = NR - 1;
        q_id.delete();
        q_op.delete();
        e_cvt_valid = 1'b0;
        e_cvt_data  = '0;
        e_rsp_valid = 1'b0;
        e_rsp_id    = '0;
        e_rsp_data  = '0;
        e_err       = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cvt_valid", cvt_valid_o, 0);
        chk("rst_cvt_data", cvt_data_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
    endtask

    // One clock: entered and left at a negedge with inputs already driven.
    task automatic step();
        logic [NR-1:0] er;
        logic          upd, popn;
        logic [7:0]    dat;
        int            w;
        #1;
        upd  = cvt_update_i;
        dat  = cvt_data_i;
        popn = upd && (q_id.size() > 0);
        er   = '0;
        w    = -1;
        if (en && (q_id.size() < DEPTH || popn))
            for (int k = 1; k <= NR; k++)
                if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        for (int i = 0; i < NR; i++)
            if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
        @(posedge clk);
        if (popn) begin
            e_rsp_valid = 1'b1;
            e_rsp_id    = 2'(q_id.pop_front());
            e_rsp_data  = man ? dat : f2i(q_op.pop_front());
            if (man) void'(q_op.pop_front());
        end else begin
            e_rsp_valid = 1'b0;
            if (upd) e_err = 1'b1;
        end
        if (w >= 0) begin
            q_id.push_back(w);
            q_op.push_back(req_data[w*16 +: 16]);
            m_last      = w;
            e_cvt_valid = 1'b1;
            e_cvt_data  = req_data[w*16 +: 16];
        end else begin
            e_cvt_valid = 1'b0;
        end
        @(negedge clk);
        chk("cvt_valid_o", cvt_valid_o, e_cvt_valid);
        chk("cvt_data_o", cvt_data_o, e_cvt_data);
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("rsp_id", rsp_id, e_rsp_id);
        chk("rsp_data", rsp_data, e_rsp_data);
        chk("err", err, e_err);
        chk("busy", busy, (q_id.size() != 0) || e_cvt_valid);
        if (rsp_valid) begin
            rsp_log_id.push_back(int'(rsp_id));
            rsp_log_d.push_back(rsp_data);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_id.size() != 0 || e_cvt_valid) && n < 40) begin
            step();
            n++;
        end
        chk("drain_empty", q_id.size(), 0);
    endtask

    task automatic clr_logs();
        rsp_log_id.delete();
        rsp_log_d.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] fexp [4];
        int base, n;
        fexp = '{8'h01, 8'h85, 8'hFF, 8'h00};
        req_valid = '0; req_data = '0; en = 1'b1;
        man = 1'b0; man_upd = 1'b0; man_data = '0;
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1 chk_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        model_reset();

        // round-robin fairness from the reset pointer
        req_data  = {16'h3800, 16'h5C00, 16'hC500, 16'h3C00};
        req_valid = '1;
        grant_log.delete(); clr_logs();
        repeat (8) step();
        req_valid = '0;
        drain();
        chk("rr_grants", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) chk("rr_order", grant_log[i], i % 4);
        chk("rr_rsp_cnt", rsp_log_id.size(), 8);
        for (int i = 0; i < rsp_log_id.size() && i < 4; i++) begin
            chk("rr_rsp_id", rsp_log_id[i], i);
            chk("rr_rsp_data", rsp_log_d[i], fexp[i]);
        end

        // single request latency
        req_data = '0;
        req_data[47:32] = 16'h4500;
        req_valid = 4'b0100;
        clr_logs();
        base = grant_log.size();
        step();
        req_valid = '0;
        chk("single_acc", grant_log.size() - base, 1);
        n = 0;
        while (rsp_log_id.size() == 0 && n < 20) begin step(); n++; end
        chk("single_lat", n, 5);
        if (rsp_log_id.size() != 0) begin
            chk("single_id", rsp_log_id[0], 2);
            chk("single_data", rsp_log_d[0], 8'h05);
        end else chk("single_rsp", 0, 1);
        drain();

        // en dropped after three accepts
        for (int i = 0; i < NR; i++) req_data[i*16 +: 16] = 16'($urandom);
        req_valid = '1;
        clr_logs();
        base = grant_log.size();
        repeat (3) step();
        en = 1'b0;
        n = 0;
        while (q_id.size() != 0 && n < 20) begin step(); n++; end
        repeat (3) step();
        chk("en_accepts", grant_log.size() - base, 3);
        chk("en_rsps", rsp_log_id.size(), 3);
        chk("en_busy_low", busy, 0);
        req_valid = '0;
        en = 1'b1;

        // randomized traffic
        repeat (400) begin
            en = ($urandom % 8) != 0;
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++)
                req_data[i*16 +: 16] = {1'($urandom), 5'($urandom_range(13, 23)), 10'($urandom)};
            step();
        end
        req_valid = '0;
        en = 1'b1;
        drain();
        repeat (LAT + 2) step();

        // back-pressure with a stalled converter
        man = 1'b1; man_upd = 1'b0;
        req_valid = '1;
        clr_logs();
        base = grant_log.size();
        repeat (10) step();
        chk("bp_accepts", grant_log.size() - base, DEPTH);
        #1 chk("bp_ready_low", req_ready, 0);
        man_upd = 1'b1; man_data = 8'h11;
        #1 chk("bp_recover", |req_ready, 1);
        step();
        req_valid = '0;
        n = 0;
        while (q_id.size() != 0 && n < 20) begin man_data = 8'($urandom); step(); n++; end
        man_upd = 1'b0;
        chk("bp_rsp_cnt", rsp_log_id.size(), DEPTH + 1);
        for (int i = 0; i < rsp_log_id.size() && base + i < grant_log.size(); i++)
            chk("bp_tag_order", rsp_log_id[i], grant_log[base + i]);
        repeat (LAT + 2) step();

        // spurious update on an empty FIFO
        clr_logs();
        man_upd = 1'b1; man_data = 8'h77;
        step();
        man_upd = 1'b0;
        repeat (3) step();
        chk("err_sticky", err, 1);
        chk("spur_no_rsp", rsp_log_id.size(), 0);
        man = 1'b0;

        // reset while two conversions are in flight
        req_valid = 4'b0001;
        repeat (2) step();
        req_valid = '0;
        repeat (2) step();
        #2 rst = 1'b1;
        req_valid = '1;
        #1 chk_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        model_reset();
        clr_logs();
        repeat (15) step();
        chk("rst_no_rsp", rsp_log_id.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_cvt_arbiter.md
# fp16_cvt_arbiter

Round-robin arbiter that shares one FP16→INT8 converter pipeline among `N_REQ` requesters. It tracks the requester ID of every conversion in flight with a tag FIFO and returns each INT8 result to its owner. The block sits between the per-channel FP16 producers and the single converter instance. The converter itself has no stall input, so the arbiter is the only flow-control point.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `CVT_LAT`, default 4: clock edges from the converter sampling `input_valid` to `output_update` going high.
- `TAG_DEPTH`, default 8: tag FIFO depth. Must be ≥ `CVT_LAT`+2.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: when low, no new grants are issued; in-flight work still drains.
- `req_valid`, in, `N_REQ`: per-requester request.
- `req_data`, in, `N_REQ`×16: per-requester FP16 operand, flattened; requester i occupies bits [16i+15:16i].
- `req_ready`, out, `N_REQ`: one-hot grant (combinational).
- `cvt_valid_o`, out, 1: drives the converter's `input_valid`.
- `cvt_data_o`, out, 16: drives the converter's `data_i`.
- `cvt_data_i`, in, 8: the converter's `data_o`.
- `cvt_update_i`, in, 1: the converter's `output_update`.
- `rsp_valid`, out, 1: one-cycle result pulse.
- `rsp_id`, out, `$clog2(N_REQ)`: ID of the requester that owns the result.
- `rsp_data`, out, 8: INT8 result (sign-magnitude, 0xFF = overflow).
- `busy`, out, 1: at least one conversion is outstanding.
- `err`, out, 1: sticky protocol error.

## Operation
- **Handshake.** A request from requester i is accepted at a clock edge where `req_valid[i]` and `req_ready[i]` are both high. At most one grant is issued per cycle.
- **Grant condition.** `req_ready` is all-zero when any of the following holds: `en` is low, the FIFO is full and no pop occurs this cycle, or `rst` is asserted.
- **Round-robin.** Pointer `last` holds the ID of the last accepted requester (reset value `N_REQ`-1). Search order is `last`+1, `last`+2, …, wrapping modulo `N_REQ`. The first requester with `req_valid` high gets the grant. `last` updates only on an accepted request.
- **Issue.** On acceptance, `cvt_valid_o` is set to 1 for one cycle, `cvt_data_o` is set to the operand, and the ID is pushed into the tag FIFO. When no request is accepted, `cvt_valid_o` is 0 and `cvt_data_o` holds its last value.
- **Retire.** When `cvt_update_i` is high, one tag is popped. On the next edge, `rsp_valid` is 1, `rsp_id` is the popped tag, and `rsp_data` is `cvt_data_i`. When `cvt_update_i` is low, `rsp_valid` is 0 and `rsp_id`/`rsp_data` hold their values.
- **Simultaneous push and pop.** Both are allowed in the same cycle. The count is unchanged, and a full FIFO still accepts a push when a pop occurs in the same cycle.
- **Underflow.** If `cvt_update_i` is high while the FIFO is empty, `err` is set to 1, no response is generated, and the FIFO state is unchanged.
- **`err` clearing.** `err` is cleared only by `rst`.
- **`busy`.** Asserted when FIFO count ≠ 0 or `cvt_valid_o` = 1.
- **`en` deasserted mid-stream.** Outstanding results still return. `busy` falls after the last pop.
- **Reset.** Asserting `rst` at any time clears all state asynchronously; in-flight conversions are discarded. The converter shares `rst`, so no stale `cvt_update_i` arrives afterwards.
- **Output reset values.** `req_ready`=0, `cvt_valid_o`=0, `cvt_data_o`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, `err`=0. Internal reset values: `last`=`N_REQ`-1, FIFO empty.

## Timing
- If acceptance occurs at edge e, the converter samples at e+1 and raises `cvt_update_i` after edge e+1+`CVT_LAT`−1 = e+`CVT_LAT`. `rsp_valid` rises after edge e+`CVT_LAT`+1, which is 5 edges with the default.
- Throughput is one request per cycle sustained. Results return in acceptance order.
- `req_ready` is combinational from `req_valid`, `en`, FIFO state and `last`. All other outputs are registered.

## Structure
- **Package `fp16_cvt_pkg`:** `N_REQ` default, `CVT_LAT` default, `TAG_DEPTH` default, and typedef `req_id_t` = logic [$clog2(N_REQ)-1:0].
- **Sub-module `cvt_tag_fifo`:** synchronous FIFO with width `req_id_t` and depth `TAG_DEPTH`.
  - Ports: push, pop, din, dout (first-word fall-through), full, empty, count.
  - Same `clk`/`rst`.
  - Wrap-around read/write pointers.
- The top level contains the round-robin arbiter, issue registers, response registers and `err` logic. Bench it with the existing `FP162INT8` instance attached.

## Test plan
- **Single request.** Requester 2 sends 0x4500 (5.0) → `rsp_valid` rises 5 edges after acceptance with `rsp_id`=2, `rsp_data`=0x05.
- **Round-robin fairness.** All 4 requesters hold `req_valid` high with 0x3C00, 0xC500, 0x5C00, 0x3800 → grants go in order 0,1,2,3,0…. Responses return in that order with data 0x01, 0x85, 0xFF, 0x00.
- **Back-pressure.** Set `TAG_DEPTH`=`CVT_LAT`+2 and drive the converter model's `cvt_update_i` low (stalled) → `req_ready` drops after 6 accepts and recovers on the first pop. No tag is lost.
- **`en` low mid-burst.** After 3 accepts, drive `en`=0 → no further grants, 3 responses still arrive, `busy` falls the cycle after the last pop.
- **Spurious update.** Pulse `cvt_update_i` with an empty FIFO → `err`=1 and `rsp_valid` stays 0. `err` stays 1 until `rst`.
- **Reset mid-flight.** Assert `rst` 2 cycles after 2 accepts → all outputs return to their reset values immediately. No `rsp_valid` appears after `rst` is released.
